// File: rtl/game_countdown_timer_if.sv
// Control and display bundle between the game FSM / HUD and the countdown timer.
// The game controller drives start/hold/clear; the timer returns BCD digits and status.
interface game_countdown_timer_if;
    logic       start;
    logic       hold;
    logic       clear;
    logic [3:0] timerdig2;
    logic [3:0] timerdig1;
    logic [3:0] timerdig0;
    logic       running;
    logic       paused;
    logic       time_up;
    logic       time_up_pulse;

    modport master (
        output start, hold, clear,
        input  timerdig2, timerdig1, timerdig0,
        input  running, paused, time_up, time_up_pulse
    );

    modport slave (
        input  start, hold, clear,
        output timerdig2, timerdig1, timerdig0,
        output running, paused, time_up, time_up_pulse
    );
endinterface

// File: rtl/game_countdown_timer.sv
// Round countdown timer: counts M:SS down to 0:00 in whole seconds, one tick
// every TICK_DIV clocks of RUN, and reports running/paused/expired status.
module game_countdown_timer #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int PRESET_MIN  = 3,
    parameter int PRESET_SECT = 0,
    parameter int PRESET_SECO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    game_countdown_timer_if.slave tmr
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]     P_DIG2     = 4'(PRESET_MIN);
    localparam logic [3:0]     P_DIG1     = 4'(PRESET_SECT);
    localparam logic [3:0]     P_DIG0     = 4'(PRESET_SECO);
    // A zero preset expires immediately on start instead of counting.
    localparam logic           P_ZERO     = (PRESET_MIN == 0) && (PRESET_SECT == 0) && (PRESET_SECO == 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    dig2_q, dig2_d;
    logic [3:0]    dig1_q, dig1_d;
    logic [3:0]    dig0_q, dig0_d;
    logic          running_q, running_d;
    logic          paused_q, paused_d;
    logic          time_up_q, time_up_d;
    logic          time_up_pulse_q, time_up_pulse_d;

    logic [3:0]    dec2, dec1, dec0;
    logic          borrow0, borrow1;
    logic          dec_zero;

    // One-second BCD decrement of the current digits (used only on a tick).
    always_comb begin
        dec0    = dig0_q;
        dec1    = dig1_q;
        dec2    = dig2_q;
        borrow0 = 1'b0;
        borrow1 = 1'b0;
        if (dig0_q != 4'd0) begin
            dec0 = dig0_q - 4'd1;
        end else begin
            dec0    = 4'd9;
            borrow0 = 1'b1;
        end
        if (borrow0) begin
            if (dig1_q != 4'd0) begin
                dec1 = dig1_q - 4'd1;
            end else begin
                dec1    = 4'd5;
                borrow1 = 1'b1;
            end
        end
        if (borrow1) begin
            dec2 = dig2_q - 4'd1;
        end
        dec_zero = (dec2 == 4'd0) && (dec1 == 4'd0) && (dec0 == 4'd0);
    end

    // Next-state, prescaler and digit logic; priority clear > start > hold > tick.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        dig2_d  = dig2_q;
        dig1_d  = dig1_q;
        dig0_d  = dig0_q;
        if (tmr.clear) begin
            state_d = IDLE;
            presc_d = '0;
            dig2_d  = P_DIG2;
            dig1_d  = P_DIG1;
            dig0_d  = P_DIG0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (tmr.start) begin
                        state_d = P_ZERO ? DONE : RUN;
                        presc_d = '0;
                        dig2_d  = P_DIG2;
                        dig1_d  = P_DIG1;
                        dig0_d  = P_DIG0;
                    end
                end
                RUN: begin
                    if (tmr.hold) begin
                        // Freeze everything, including a prescaler sitting at its last count.
                        state_d = PAUSED;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        dig2_d  = dec2;
                        dig1_d  = dec1;
                        dig0_d  = dec0;
                        if (dec_zero) begin
                            state_d = DONE;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSED: begin
                    if (!tmr.hold) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        running_d       = (state_d == RUN);
        paused_d        = (state_d == PAUSED);
        time_up_d       = (state_d == DONE);
        time_up_pulse_d = (state_d == DONE) && (state_q != DONE);
    end

    // State, prescaler, digit and status registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            presc_q         <= '0;
            dig2_q          <= P_DIG2;
            dig1_q          <= P_DIG1;
            dig0_q          <= P_DIG0;
            running_q       <= 1'b0;
            paused_q        <= 1'b0;
            time_up_q       <= 1'b0;
            time_up_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            presc_q         <= presc_d;
            dig2_q          <= dig2_d;
            dig1_q          <= dig1_d;
            dig0_q          <= dig0_d;
            running_q       <= running_d;
            paused_q        <= paused_d;
            time_up_q       <= time_up_d;
            time_up_pulse_q <= time_up_pulse_d;
        end
    end

    assign tmr.timerdig2     = dig2_q;
    assign tmr.timerdig1     = dig1_q;
    assign tmr.timerdig0     = dig0_q;
    assign tmr.running       = running_q;
    assign tmr.paused        = paused_q;
    assign tmr.time_up       = time_up_q;
    assign tmr.time_up_pulse = time_up_pulse_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench for game_countdown_timer (TICK_DIV = 4, preset 3:00).
// Stimulus pushes each expected output change with the cycle it must appear on;
// the monitor pops and compares whenever the DUT outputs change.
module tb_game_countdown_timer;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    game_countdown_timer_if bus ();

    game_countdown_timer #(
        .TICK_DIV    (4),
        .PRESET_MIN  (3),
        .PRESET_SECT (0),
        .PRESET_SECO (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tmr   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    typedef struct {
        int          cyc;   // -1: any cycle
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic stim_done = 1'b0;

    function automatic logic [15:0] outs(int d2, int d1, int d0, bit run, bit pau, bit tu, bit tup);
        logic [15:0] v;
        v = {4'(d2), 4'(d1), 4'(d0), run, pau, tu, tup};
        return v;
    endfunction

    // Expected outputs while counting, from a remaining-seconds value.
    function automatic logic [15:0] secs_run(int s);
        return outs(s / 60, (s % 60) / 10, s % 10, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic expect_at(int dly, string nm, logic [15:0] v);
        exp_t e;
        e.cyc  = (dly < 0) ? -1 : cyc + dly;
        e.val  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    // One expected change per tick (every 4 cycles), ending in DONE if 0:00 is reached.
    task automatic push_countdown(int from_s, int n_ticks);
        int s;
        for (int k = 1; k <= n_ticks; k++) begin
            s = from_s - k;
            if (s == 0) begin
                expect_at(4 * k, "reach_zero", outs(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1));
                expect_at(4 * k + 1, "pulse_end", outs(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
            end else begin
                expect_at(4 * k, $sformatf("tick_to_%0d:%0d%0d", s / 60, (s % 60) / 10, s % 10),
                          secs_run(s));
            end
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare on every output change, flag expected changes that never came.
    initial begin
        logic [15:0] snap;
        logic [15:0] prev;
        exp_t        e;
        prev = 16'hFFFF;
        forever begin
            @(negedge clk);
            snap = {bus.timerdig2, bus.timerdig1, bus.timerdig0,
                    bus.running, bus.paused, bus.time_up, bus.time_up_pulse};
            if (snap !== prev) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change cyc=%0d got=%h prev=%h", cyc, snap, prev);
                end else begin
                    e = sb_q.pop_front();
                    if (snap !== e.val || (e.cyc >= 0 && e.cyc != cyc)) begin
                        n_fail++;
                        $display("FAIL %s cyc=%0d got=%h required=%h at cyc %0d",
                                 e.name, cyc, snap, e.val, e.cyc);
                    end else begin
                        $display("ok   %s cyc=%0d out=%h", e.name, cyc, snap);
                    end
                end
                prev = snap;
            end else if (sb_q.size() > 0 && sb_q[0].cyc >= 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL %s missed cyc=%0d got=%h required=%h at cyc %0d",
                         e.name, cyc, snap, e.val, e.cyc);
            end
        end
    end

    // Directed stimulus.
    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        bus.clear = 1'b0;
        expect_at(-1, "reset_state", outs(3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(2);
        reset = 1'b0;
        step(20);                       // idle: nothing may change

        // Full countdown 3:00 -> 0:00
        bus.start = 1'b1;
        expect_at(1, "start", outs(3, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1);
        bus.start = 1'b0;
        push_countdown(180, 180);
        step(730);
        bus.hold = 1'b1;                // hold in DONE is ignored
        step(3);
        bus.hold = 1'b0;
        step(2);

        // Restart from DONE
        bus.start = 1'b1;
        expect_at(1, "restart", outs(3, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1);
        bus.start = 1'b0;
        expect_at(4, "restart_tick", secs_run(179));
        step(6);                        // prescaler now 2

        // Pause with prescaler at 2 for 10 cycles
        bus.hold = 1'b1;
        expect_at(1, "pause", outs(2, 5, 9, 1'b0, 1'b1, 1'b0, 1'b0));
        step(10);
        bus.hold = 1'b0;
        expect_at(1, "resume", secs_run(179));
        expect_at(3, "tick_after_pause", secs_run(178));
        step(6);                        // prescaler now 3 (wrap cycle)

        // Hold on the wrap cycle suppresses the tick
        bus.hold = 1'b1;
        expect_at(1, "hold_at_wrap", outs(2, 5, 8, 1'b0, 1'b1, 1'b0, 1'b0));
        step(1);
        bus.hold = 1'b0;
        expect_at(1, "resume_wrap", secs_run(178));
        expect_at(2, "tick_after_wrap_hold", secs_run(177));
        step(2);

        // Count to 1:23; a start pulse in RUN must be ignored
        push_countdown(177, 94);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(4 * 94);
        step(1);
        bus.clear = 1'b1;
        expect_at(1, "clear_run", outs(3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1);
        bus.clear = 1'b0;
        step(3);

        // clear + start together in IDLE: stays IDLE
        bus.clear = 1'b1;
        bus.start = 1'b1;
        step(1);
        bus.clear = 1'b0;
        bus.start = 1'b0;
        step(4);

        // Second full run, then clear + start in DONE
        bus.start = 1'b1;
        expect_at(1, "start2", outs(3, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1);
        bus.start = 1'b0;
        push_countdown(180, 180);
        step(725);
        bus.clear = 1'b1;
        bus.start = 1'b1;
        expect_at(1, "clear_start_done", outs(3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1);
        bus.clear = 1'b0;
        bus.start = 1'b0;
        step(3);

        // Async reset mid-second at 2:17
        bus.start = 1'b1;
        expect_at(1, "start3", outs(3, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1);
        bus.start = 1'b0;
        push_countdown(180, 43);
        step(174);
        reset = 1'b1;
        expect_at(0, "async_reset", outs(3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(2);
        reset = 1'b0;
        step(5);

        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s never_seen required=%h at cyc %0d", e.name, e.val, e.cyc);
        end
        stim_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #500000;
        if (!stim_done) begin
            n_fail++;
            $display("FAIL timeout cyc=%0d required=stimulus complete", cyc);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

endmodule
